// File: rtl/aes_cozucu_if.sv
// aes_cozucu_if
//   Bundles the block-level handshake and data buses of the AES-128
//   decryption engine.
//
//   Handshake (valid/ready):
//     A block is accepted on a rising edge where g_gecerli=1 and hazir=1.
//     The ready signal hazir is high exactly while the engine is idle.
//     g_gecerli raised while hazir=0 is dropped and never queued.
//     The result is delivered with a one-cycle c_gecerli strobe. blok is valid
//     in that cycle and is held until the next result. The result side has no
//     back-pressure.
//
//   Signals:
//     anahtar   [127:0]  cipher key, captured on accept
//     sifre     [127:0]  ciphertext block, captured on accept
//     g_gecerli          input valid
//     hazir              engine idle / ready to accept
//     blok      [127:0]  plaintext result
//     c_gecerli          one-cycle result strobe
//     dbg_durum [1:0]    current FSM state (0 IDLE, 1 KEY, 2 ROUND)
interface aes_cozucu_if;
    logic [127:0] anahtar;
    logic [127:0] sifre;
    logic         g_gecerli;
    logic         hazir;
    logic [127:0] blok;
    logic         c_gecerli;
    logic [1:0]   dbg_durum;

    modport master (
        output anahtar, sifre, g_gecerli,
        input  hazir, blok, c_gecerli, dbg_durum
    );

    modport slave (
        input  anahtar, sifre, g_gecerli,
        output hazir, blok, c_gecerli, dbg_durum
    );
endinterface

// File: rtl/aes_cozucu.sv
// aes_cozucu
//   Iterative AES-128 decryption engine that computes one round per clock.
//   After accepting a block, the engine expands the key forward to round
//   key 10 in 10 cycles. It then runs 10 inverse rounds and walks the key
//   schedule backwards at the same time, so no round-key storage is needed.
//   Accept-to-result latency is 20 clocks, and a new block can be accepted
//   in the result cycle.
//
//   Ports:
//     clk   single clock; all state changes on its rising edge
//     rst   synchronous, active-low reset
//     bus   aes_cozucu_if.slave (key/ciphertext in, plaintext out, handshake)
//
//   Byte order: byte 0 is bits [127:120]. The state is column-major, so
//   bytes 0..3 form column 0.
module aes_cozucu (
    input  logic        clk,
    input  logic        rst,
    aes_cozucu_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        KEY   = 2'd1,
        ROUND = 2'd2
    } durum_e;

    durum_e       durum_q, durum_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] blok_q, blok_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         c_gecerli_q, c_gecerli_d;

    // ------------------------------------------------------------------
    // GF(2^8) helpers. The S-boxes are computed as the field inverse plus
    // the affine map, not stored as tables.
    // ------------------------------------------------------------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 = a^-1 for a != 0; it also maps 0 to 0, which the S-box needs.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] i;
        i = ginv(b);
        return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]}
                 ^ {i[3:0], i[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] t;
        t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return ginv(t);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Row r is rotated right by r: out[r][c] = in[r][(c - r) mod 4].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r) & 3)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
                inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
    endfunction

    // ------------------------------------------------------------------
    // Key schedule datapath. The forward and backward steps share one
    // RotWord/SubWord/Rcon block. Going forward it takes column 3 of rk_q.
    // Going backward it takes the recovered previous column 3, which is
    // c3 ^ c2. Both directions use Rcon[cnt+1]: KEY counts 0..9 up, and
    // ROUND counts r = 9..0 down and undoes step r+1.
    // ------------------------------------------------------------------
    logic [31:0]  k_word;
    logic [31:0]  k_g;
    logic [31:0]  f0, f1, f2, f3;
    logic [127:0] rk_fwd;
    logic [127:0] rk_bwd;
    logic [127:0] rnd_add;
    logic [127:0] rnd_out;

    assign k_word = (durum_q == ROUND) ? (rk_q[31:0] ^ rk_q[63:32]) : rk_q[31:0];
    assign k_g    = {sbox(k_word[23:16]) ^ rcon(cnt_q + 4'd1), sbox(k_word[15:8]),
                     sbox(k_word[7:0]), sbox(k_word[31:24])};

    assign f0     = rk_q[127:96] ^ k_g;
    assign f1     = rk_q[95:64]  ^ f0;
    assign f2     = rk_q[63:32]  ^ f1;
    assign f3     = rk_q[31:0]   ^ f2;
    assign rk_fwd = {f0, f1, f2, f3};

    assign rk_bwd = {rk_q[127:96] ^ k_g,
                     rk_q[95:64]  ^ rk_q[127:96],
                     rk_q[63:32]  ^ rk_q[95:64],
                     rk_q[31:0]   ^ rk_q[63:32]};

    // Inverse round. The final round (r = 0) skips InvMixColumns.
    assign rnd_add = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_bwd;
    assign rnd_out = (cnt_q == 4'd0) ? rnd_add : inv_mix_columns(rnd_add);

    // ------------------------------------------------------------------
    // FSM: next state and datapath register updates
    // ------------------------------------------------------------------
    always_comb begin
        durum_d     = durum_q;
        st_d        = st_q;
        rk_d        = rk_q;
        cnt_d       = cnt_q;
        blok_d      = blok_q;
        c_gecerli_d = 1'b0;
        case (durum_q)
            IDLE: begin
                if (bus.g_gecerli) begin
                    st_d    = bus.sifre;
                    rk_d    = bus.anahtar;
                    cnt_d   = 4'd0;
                    durum_d = KEY;
                end
            end
            KEY: begin
                rk_d = rk_fwd;
                if (cnt_q == 4'd9) begin
                    // Initial AddRoundKey uses the freshly expanded round key 10.
                    st_d    = st_q ^ rk_fwd;
                    cnt_d   = 4'd9;
                    durum_d = ROUND;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ROUND: begin
                rk_d = rk_bwd;
                st_d = rnd_out;
                if (cnt_q == 4'd0) begin
                    blok_d      = rnd_out;
                    c_gecerli_d = 1'b1;
                    durum_d     = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                durum_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            durum_q     <= IDLE;
            st_q        <= '0;
            rk_q        <= '0;
            blok_q      <= '0;
            cnt_q       <= '0;
            c_gecerli_q <= 1'b0;
        end else begin
            durum_q     <= durum_d;
            st_q        <= st_d;
            rk_q        <= rk_d;
            blok_q      <= blok_d;
            cnt_q       <= cnt_d;
            c_gecerli_q <= c_gecerli_d;
        end
    end

    assign bus.hazir     = (durum_q == IDLE);
    assign bus.blok      = blok_q;
    assign bus.c_gecerli = c_gecerli_q;
    assign bus.dbg_durum = durum_q;

endmodule
